// File: rtl/mole_spawn_scheduler.sv
// Purpose : schedules a random gap, raises one mole for a bounded number of ticks, reports hit or miss.
// Latency : all outputs registered; score_pulse/miss_pulse rise 1 cycle after the deciding hit/tick is sampled.
// Backpr. : none; enable=0 drops to IDLE at the next edge, clearing the mole with no pulses.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   enable       game running; low forces IDLE
//   tick         one-cycle game-rate strobe
//   rnd          5-bit LFSR word, sampled when a gap is loaded or a hole is chosen
//   hit          per-hole whack inputs (level)
//   mole         one-hot visible mole, zero when none is up
//   hole_idx     index of the current or last mole
//   score_pulse  one-cycle pulse on a successful hit
//   miss_pulse   one-cycle pulse when a mole expires unhit
//   hit_cnt      total hits, wraps 255 -> 0
//
// Build option: define SPEEDUP_EN to shorten the up time by one tick every 4th
// hit, saturating at MIN_UP. Without it the up time is always UP_TICKS.

module mole_spawn_scheduler #(
    parameter int N_HOLES  = 9,
    parameter int UP_TICKS = 6,
    parameter int GAP_MIN  = 1,
    parameter int MIN_UP   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic [4:0]         rnd,
    input  logic [N_HOLES-1:0] hit,
    output logic [N_HOLES-1:0] mole,
    output logic [3:0]         hole_idx,
    output logic               score_pulse,
    output logic               miss_pulse,
    output logic [7:0]         hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GAP    = 2'd1,
        S_UP     = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [3:0]         UP_LEN_RST = 4'(UP_TICKS);
    localparam logic [3:0]         GAP_BASE   = 4'(GAP_MIN);
    localparam logic [4:0]         HOLES_W    = 5'(N_HOLES);
    localparam logic [3:0]         LAST_IDX   = 4'(N_HOLES - 1);
    localparam logic [N_HOLES-1:0] ONE_HOT0   = {{(N_HOLES-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic [3:0]         up_cnt, up_cnt_nxt;
    logic [3:0]         up_len;
    logic [3:0]         last_hole, last_hole_nxt;
    logic [N_HOLES-1:0] mole_nxt;
    logic [3:0]         hole_idx_nxt;
    logic               score_nxt, miss_nxt;
    logic [7:0]         hit_cnt_nxt;

    // Gap length for the next wait, taken from the top two LFSR bits.
    logic [3:0] gap_load;
    assign gap_load = {2'b00, rnd[4:3]} + GAP_BASE;

    // Hole choice: rnd mod N_HOLES, bumped by one (with wrap) when it would
    // repeat the previous hole so the same hole never appears twice in a row.
    logic [3:0] pick_raw;
    logic [3:0] pick;
    assign pick_raw = 4'(rnd % HOLES_W);

    always_comb begin
        pick = pick_raw;
        if (pick_raw == last_hole) begin
            pick = (pick_raw == LAST_IDX) ? 4'd0 : pick_raw + 4'd1;
        end
    end

    logic mole_struck;
    assign mole_struck = |(hit & mole);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        gap_cnt_nxt   = gap_cnt;
        up_cnt_nxt    = up_cnt;
        last_hole_nxt = last_hole;
        mole_nxt      = mole;
        hole_idx_nxt  = hole_idx;
        score_nxt     = 1'b0;
        miss_nxt      = 1'b0;
        hit_cnt_nxt   = hit_cnt;

        if (!enable) begin
            state_nxt = S_IDLE;
            mole_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = gap_load;
                end
                S_GAP: begin
                    if (tick) begin
                        // <=1 rather than ==1 so a zero count can never stall the game.
                        if (gap_cnt <= 4'd1) begin
                            state_nxt     = S_UP;
                            mole_nxt      = ONE_HOT0 << pick;
                            hole_idx_nxt  = pick;
                            last_hole_nxt = pick;
                            up_cnt_nxt    = up_len;
                        end else begin
                            gap_cnt_nxt = gap_cnt - 4'd1;
                        end
                    end
                end
                S_UP: begin
                    // A hit wins over expiry on the same cycle.
                    if (mole_struck) begin
                        state_nxt   = S_RESULT;
                        mole_nxt    = '0;
                        score_nxt   = 1'b1;
                        hit_cnt_nxt = hit_cnt + 8'd1;
                    end else if (tick) begin
                        if (up_cnt <= 4'd1) begin
                            state_nxt = S_RESULT;
                            mole_nxt  = '0;
                            miss_nxt  = 1'b1;
                        end else begin
                            up_cnt_nxt = up_cnt - 4'd1;
                        end
                    end
                end
                S_RESULT: begin
                    // tick is deliberately ignored here.
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = gap_load;
                end
                default: begin
                    state_nxt = S_IDLE;
                    mole_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            up_cnt      <= '0;
            last_hole   <= '0;
            mole        <= '0;
            hole_idx    <= '0;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            hit_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_cnt_nxt;
            up_cnt      <= up_cnt_nxt;
            last_hole   <= last_hole_nxt;
            mole        <= mole_nxt;
            hole_idx    <= hole_idx_nxt;
            score_pulse <= score_nxt;
            miss_pulse  <= miss_nxt;
            hit_cnt     <= hit_cnt_nxt;
        end
    end

`ifdef SPEEDUP_EN
    // Every 4th hit (count landing on a multiple of 4) shortens the next moles.
    localparam logic [3:0] MIN_LEN = 4'(MIN_UP);
    logic [3:0] up_len_nxt;
    logic       speed_step;
    assign speed_step = score_nxt && (hit_cnt_nxt[1:0] == 2'b00);

    always_comb begin
        up_len_nxt = up_len;
        if (speed_step && (up_len > MIN_LEN)) begin
            up_len_nxt = up_len - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_len <= UP_LEN_RST;
        end else begin
            up_len <= up_len_nxt;
        end
    end
`else
    assign up_len = UP_LEN_RST;
`endif

endmodule

// File: tb/tb_mole_spawn_scheduler.sv
module tb_mole_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       tick;
    logic [4:0] rnd;
    logic [8:0] hit;
    logic [8:0] mole;
    logic [3:0] hole_idx;
    logic       score_pulse;
    logic       miss_pulse;
    logic [7:0] hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mole_spawn_scheduler #(
        .N_HOLES (9),
        .UP_TICKS(6),
        .GAP_MIN (1),
        .MIN_UP  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .rnd        (rnd),
        .hit        (hit),
        .mole       (mole),
        .hole_idx   (hole_idx),
        .score_pulse(score_pulse),
        .miss_pulse (miss_pulse),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; tick = 1'b0; rnd = 5'd0; hit = 9'h000;
        idle(2);
        chk("rst_mole",     mole, 0);
        chk("rst_hole_idx", hole_idx, 0);
        chk("rst_score",    score_pulse, 0);
        chk("rst_miss",     miss_pulse, 0);
        chk("rst_hit_cnt",  hit_cnt, 0);

        // rnd=12: gap = 1+1 = 2 ticks, hole = 12 mod 9 = 3
        rst = 1'b0; enable = 1'b1; rnd = 5'd12;
        step();
        chk("gap_entry_mole", mole, 0);
        do_tick();
        chk("gap_tick1_mole", mole, 0);
        idle(3);
        do_tick();
        chk("up1_mole",     mole, 9'h008);
        chk("up1_hole_idx", hole_idx, 3);

        // hit on the 3rd UP tick cycle
        idle(3); do_tick();
        idle(3); do_tick();
        idle(3);
        tick = 1'b1; hit = 9'h008;
        step();
        chk("hit1_score",   score_pulse, 1);
        chk("hit1_miss",    miss_pulse, 0);
        chk("hit1_mole",    mole, 0);
        chk("hit1_hit_cnt", hit_cnt, 1);
        tick = 1'b0; hit = 9'h000;
        step();
        chk("hit1_score_drop", score_pulse, 0);

        // rnd=12 again repeats hole 3 -> bumped to 4
        do_tick(); idle(3); do_tick();
        chk("up2_mole",     mole, 9'h010);
        chk("up2_hole_idx", hole_idx, 4);
        for (int i = 0; i < 5; i++) begin
            idle(3); do_tick();
        end
        chk("up2_5ticks_mole", mole, 9'h010);
        chk("up2_5ticks_miss", miss_pulse, 0);
        idle(3); do_tick();
        chk("miss_pulse",   miss_pulse, 1);
        chk("miss_score",   score_pulse, 0);
        chk("miss_mole",    mole, 0);
        chk("miss_hit_cnt", hit_cnt, 1);

        // rnd=17: gap = 2+1 = 3 ticks, hole = 17 mod 9 = 8
        rnd = 5'd17;
        step();
        chk("miss_drop", miss_pulse, 0);
        do_tick(); idle(1); do_tick(); idle(1); do_tick();
        chk("up3_mole",     mole, 9'h100);
        chk("up3_hole_idx", hole_idx, 8);
        hit = 9'h001;
        step();
        chk("wrong_hole_score", score_pulse, 0);
        chk("wrong_hole_mole",  mole, 9'h100);
        hit = 9'h000;
        for (int i = 0; i < 5; i++) begin
            do_tick(); idle(1);
        end
        // hit and final tick together: hit wins
        tick = 1'b1; hit = 9'h100;
        step();
        chk("tie_score",   score_pulse, 1);
        chk("tie_miss",    miss_pulse, 0);
        chk("tie_hit_cnt", hit_cnt, 2);
        tick = 1'b0;
        step();

        // hit held on hole 8; rnd=17 repeats 8 -> wraps to 0
        do_tick(); idle(1); do_tick(); idle(1); do_tick();
        chk("wrap_mole",     mole, 9'h001);
        chk("wrap_hole_idx", hole_idx, 0);
        step();
        chk("held_hit_score", score_pulse, 0);
        chk("held_hit_mole",  mole, 9'h001);

        // enable low mid-UP
        enable = 1'b0;
        step();
        chk("dis_mole",    mole, 0);
        chk("dis_score",   score_pulse, 0);
        chk("dis_miss",    miss_pulse, 0);
        chk("dis_hit_cnt", hit_cnt, 2);
        do_tick();
        chk("dis_tick_mole", mole, 0);

        // rnd=0: gap 1, hole 0 repeats last 0 -> 1; then reset mid-UP
        hit = 9'h000; enable = 1'b1; rnd = 5'd0;
        step();
        do_tick();
        chk("up4_mole",     mole, 9'h002);
        chk("up4_hole_idx", hole_idx, 1);
        rst = 1'b1;
        step();
        chk("rst_up_mole",     mole, 0);
        chk("rst_up_hit_cnt",  hit_cnt, 0);
        chk("rst_up_hole_idx", hole_idx, 0);
        chk("rst_up_score",    score_pulse, 0);
        rst = 1'b0;

`ifdef SPEEDUP_EN
        hit = 9'h1FF; rnd = 5'd0;
        step();
        for (int k = 1; k <= 20; k++) begin
            do_tick();
            step();
            step();
            if (k == 4)  chk("speed_len_4",  dut.up_len, 5);
            if (k == 16) chk("speed_len_16", dut.up_len, 2);
            if (k == 20) chk("speed_len_20", dut.up_len, 2);
        end
        chk("speed_hit_cnt", hit_cnt, 20);
        hit = 9'h000;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
